// File: rtl/renode_ahb_manager_bridge.sv
// Valid/ready request stream to AHB-Lite manager bridge.
// Two-stage address/data pipeline with error-cancel and local request rejection.
module renode_ahb_manager_bridge #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [AddressWidth-1:0] req_addr,
    input  logic                    req_write,
    input  logic [2:0]              req_size,
    input  logic [DataWidth-1:0]    req_wdata,
    output logic                    resp_valid,
    output logic [DataWidth-1:0]    resp_rdata,
    output logic                    resp_error,
    output logic [AddressWidth-1:0] haddr,
    output logic [1:0]              htrans,
    output logic                    hwrite,
    output logic [2:0]              hsize,
    output logic [2:0]              hburst,
    output logic [DataWidth-1:0]    hwdata,
    input  logic [DataWidth-1:0]    hrdata,
    input  logic                    hready,
    input  logic                    hresp
);

    localparam int         MaxSize     = $clog2(DataWidth / 8);
    localparam logic [2:0] MaxSizeL    = 3'(MaxSize);
    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    typedef enum logic [1:0] {
        ApIdle,
        ApBusy,
        ApCancel
    } ap_state_e;

    ap_state_e ap_state;
    ap_state_e ap_state_next;

    logic [DataWidth-1:0] ap_wdata;
    logic                 dp_valid;
    logic                 dp_write;

    logic [7:0] align_mask;
    logic       req_bad;
    logic       err_first;
    logic       dp_done;
    logic       ap_adv;
    logic       can_take;
    logic       take_good;
    logic       take_bad;

    always_comb begin
        align_mask = (8'd1 << req_size) - 8'd1;
        req_bad    = (req_size > MaxSizeL)
                   || ((req_addr[7:0] & align_mask) != 8'd0);
    end

    // First error cycle: subordinate signals ERROR while still stalling.
    always_comb begin
        err_first = dp_valid & hresp & ~hready;
        dp_done   = dp_valid & hready;
        ap_adv    = (ap_state == ApBusy) & hready;
        can_take  = (ap_state == ApIdle) | ap_adv;
    end

    // Rejected requests wait for an empty pipe so their error stays in order.
    always_comb begin
        if (req_bad) begin
            req_ready = (ap_state == ApIdle) & ~dp_valid;
        end else begin
            req_ready = can_take;
        end
        take_good = req_valid & req_ready & ~req_bad;
        take_bad  = req_valid & req_ready & req_bad;
    end

    always_comb begin
        ap_state_next = ap_state;
        unique case (ap_state)
            ApIdle: begin
                if (take_good) begin
                    ap_state_next = ApBusy;
                end
            end
            ApBusy: begin
                if (err_first) begin
                    ap_state_next = ApCancel;
                end else if (hready) begin
                    ap_state_next = take_good ? ApBusy : ApIdle;
                end
            end
            ApCancel: begin
                if (hready) begin
                    ap_state_next = ApBusy;
                end
            end
            default: ap_state_next = ApIdle;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            ap_state <= ApIdle;
        end else begin
            ap_state <= ap_state_next;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            haddr    <= '0;
            hwrite   <= 1'b0;
            hsize    <= 3'd0;
            ap_wdata <= '0;
        end else if (take_good) begin
            haddr    <= req_addr;
            hwrite   <= req_write;
            hsize    <= req_size;
            ap_wdata <= req_wdata;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            hwdata   <= '0;
        end else if (ap_adv) begin
            dp_valid <= 1'b1;
            dp_write <= hwrite;
            hwdata   <= ap_wdata;
        end else if (dp_done) begin
            dp_valid <= 1'b0;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= dp_done | take_bad;
            resp_error <= (dp_done & hresp) | take_bad;
            if (dp_done & ~hresp & ~dp_write) begin
                resp_rdata <= hrdata;
            end else begin
                resp_rdata <= '0;
            end
        end
    end

    assign htrans = (ap_state == ApBusy) ? TransNonseq : TransIdle;
    assign hburst = 3'b000;

endmodule

// File: tb/tb_renode_ahb_manager_bridge.sv
// Bench for renode_ahb_manager_bridge: behavioural AHB subordinate plus
// response scoreboard.
module tb_renode_ahb_manager_bridge;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    renode_ahb_manager_bridge #(
        .AddressWidth(32),
        .DataWidth(32)
    ) dut (
        .hclk(hclk),
        .hreset(hreset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_write(req_write),
        .req_size(req_size),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_error(resp_error),
        .haddr(haddr),
        .htrans(htrans),
        .hwrite(hwrite),
        .hsize(hsize),
        .hburst(hburst),
        .hwdata(hwdata),
        .hrdata(hrdata),
        .hready(hready),
        .hresp(hresp)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;

    int          ws = 0;
    logic [31:0] err_addr  = 32'hFFFF_FFFF;
    logic [31:0] viol_addr = 32'hFFFF_FFFF;

    int nonseq_cnt = 0;
    int err2_seen  = 0;
    int err2_idle  = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return ((a >> 2) + 32'd1) * 32'h11;
    endfunction

    // Subordinate data-phase state
    logic        d_act = 1'b0;
    logic        d_write = 1'b0;
    logic        d_e2 = 1'b0;
    logic [31:0] d_addr = '0;
    int          d_cnt = 0;
    int          d_err = 0;

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = (d_act && !d_write) ? rd_of(d_addr) : 32'h0;
        if (d_act) begin
            if (d_cnt > 0) begin
                hready = 1'b0;
            end else if (d_err == 1) begin
                hresp  = 1'b1;
                hready = d_e2;
            end else if (d_err == 2) begin
                hresp = 1'b1;
            end
        end
    end

    always @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            d_act <= 1'b0;
            d_e2  <= 1'b0;
            d_cnt <= 0;
            d_err <= 0;
        end else begin
            if (d_act && d_err == 1 && d_e2 && d_cnt == 0) begin
                err2_seen <= err2_seen + 1;
                if (htrans == 2'b00) err2_idle <= err2_idle + 1;
            end
            if (hready) begin
                if (htrans == 2'b10) begin
                    d_act   <= 1'b1;
                    d_addr  <= haddr;
                    d_write <= hwrite;
                    d_cnt   <= ws;
                    d_err   <= (haddr == err_addr) ? 1 :
                               (haddr == viol_addr) ? 2 : 0;
                    d_e2    <= 1'b0;
                    nonseq_cnt <= nonseq_cnt + 1;
                end else begin
                    d_act <= 1'b0;
                end
            end else if (d_cnt > 0) begin
                d_cnt <= d_cnt - 1;
            end else if (d_err == 1) begin
                d_e2 <= 1'b1;
            end
        end
    end

    always @(negedge hclk) begin
        if (!hreset && resp_valid) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", resp_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_err", resp_error, mon_e.err);
                check("resp_rdata", resp_rdata, mon_e.data);
            end
        end
    end

    logic        p_wait = 1'b0;
    logic [31:0] p_addr = '0;

    always @(negedge hclk) begin
        if (hreset) begin
            p_wait <= 1'b0;
        end else begin
            if (p_wait && htrans == 2'b10) check("haddr_hold", haddr, p_addr);
            p_wait <= (htrans == 2'b10) && !hready;
            p_addr <= haddr;
        end
    end

    task automatic send(input logic [31:0] a, input logic w,
                        input logic [2:0] s, input logic [31:0] wd);
        exp_t e;
        logic bad;
        int   t;
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_size  = s;
        req_wdata = wd;
        for (t = 0; t < 200; t++) begin
            #1;
            if (req_ready) break;
            @(negedge hclk);
        end
        if (t >= 200) begin
            check("accept_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        bad   = (s > 3'd2) || ((a & ((32'd1 << s) - 32'd1)) != 32'd0);
        e.err = bad || (a == err_addr) || (a == viol_addr);
        e.data = (!w && !e.err) ? rd_of(a) : 32'h0;
        sb.push_back(e);
        @(posedge hclk);
        @(negedge hclk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            @(negedge hclk);
            #1;
            if (sb.size() == 0) break;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    int n0;
    int e0;
    int i0;

    initial begin
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_size  = 3'd0;
        req_wdata = '0;
        repeat (3) @(negedge hclk);
        check("rst_htrans", htrans, 2'b00);
        check("rst_haddr", haddr, 0);
        check("rst_hwdata", hwdata, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_hburst", hburst, 0);
        hreset = 1'b0;
        @(negedge hclk);
        check("rst_req_ready", req_ready, 1);

        // Single zero-wait write
        send(32'h100, 1'b1, 3'd2, 32'hDEAD_BEEF);
        check("w_htrans_c1", htrans, 2'b10);
        check("w_haddr_c1", haddr, 32'h100);
        check("w_hwrite_c1", hwrite, 1);
        check("w_hsize_c1", hsize, 2);
        @(negedge hclk);
        check("w_hwdata_c2", hwdata, 32'hDEAD_BEEF);
        check("w_htrans_c2", htrans, 2'b00);
        @(negedge hclk);
        check("w_resp_c3", resp_valid, 1);
        drain();

        // Back-to-back reads with two wait states
        ws = 2;
        n0 = nonseq_cnt;
        send(32'h0, 1'b0, 3'd2, 32'hA5A5_0000);
        send(32'h4, 1'b0, 3'd2, 32'hA5A5_0001);
        send(32'h8, 1'b0, 3'd2, 32'hA5A5_0002);
        drain();
        check("rd3_nonseq", nonseq_cnt - n0, 3);

        // Two-cycle error with a pipelined read behind it
        ws = 0;
        err_addr = 32'h200;
        n0 = nonseq_cnt;
        e0 = err2_seen;
        i0 = err2_idle;
        send(32'h200, 1'b1, 3'd2, 32'h1234_5678);
        send(32'h204, 1'b0, 3'd2, 32'h0);
        drain();
        check("err_cycles", err2_seen - e0, 1);
        check("err_cancel_idle", err2_idle - i0, 1);
        check("err_nonseq", nonseq_cnt - n0, 2);
        err_addr = 32'hFFFF_FFFF;

        // Local rejects
        n0 = nonseq_cnt;
        send(32'h0, 1'b0, 3'd3, 32'h0);
        check("rej_size_lat", resp_valid, 1);
        send(32'h102, 1'b1, 3'd2, 32'h55);
        check("rej_align_lat", resp_valid, 1);
        repeat (2) @(negedge hclk);
        check("rej_no_bus", nonseq_cnt - n0, 0);
        ws = 3;
        send(32'h10, 1'b0, 3'd2, 32'hCAFE_F00D);
        req_valid = 1'b1;
        req_addr  = 32'h102;
        req_write = 1'b0;
        req_size  = 3'd2;
        #1;
        check("rej_hold_ap", req_ready, 0);
        @(negedge hclk);
        #1;
        check("rej_hold_dp", req_ready, 0);
        req_size = 3'd3;
        req_addr = 32'h0;
        #1;
        check("rej_hold_size", req_ready, 0);
        @(negedge hclk);
        send(32'h102, 1'b0, 3'd2, 32'h0);
        check("rej_late_lat", resp_valid, 1);
        drain();

        // Reset during a stalled data phase
        ws = 5;
        send(32'h20, 1'b0, 3'd2, 32'h77);
        @(negedge hclk);
        #2;
        hreset = 1'b1;
        #1;
        check("mid_rst_htrans", htrans, 2'b00);
        check("mid_rst_haddr", haddr, 0);
        check("mid_rst_hwdata", hwdata, 0);
        check("mid_rst_resp", resp_valid, 0);
        sb.delete();
        repeat (3) @(negedge hclk);
        hreset = 1'b0;
        ws = 0;
        @(negedge hclk);
        check("post_rst_ready", req_ready, 1);
        send(32'h40, 1'b1, 3'd2, 32'h99);
        send(32'h44, 1'b0, 3'd2, 32'h0);
        drain();

        // Single-cycle error response, no cancellation
        viol_addr = 32'h300;
        n0 = nonseq_cnt;
        e0 = err2_seen;
        send(32'h300, 1'b0, 3'd2, 32'h0);
        send(32'h304, 1'b0, 3'd2, 32'h0);
        drain();
        check("viol_nonseq", nonseq_cnt - n0, 2);
        check("viol_no_err2", err2_seen - e0, 0);
        viol_addr = 32'hFFFF_FFFF;

        repeat (5) @(negedge hclk);
        check("final_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
